player_motion_ctrl: RTL and testbench
=====================================

Name: player_motion_ctrl

Overview:
- Consumes the 32-bit USB keycode word exported by the NIOS system (four HID usage bytes) and a VGA vertical-sync signal.
- Once per frame, updates player 1's screen position: walk left/right, plus a gravity-based jump state machine.
- Outputs feed the sprite/ball drawing logic and the player position PIO inputs, so software can read back the hardware position.

Parameters:
- X_INIT, 320, reset X position (left edge of sprite, pixels)
- Y_GROUND, 400, ground Y (top edge of sprite when standing); also the reset Y
- X_MIN, 0, leftmost legal X
- X_MAX, 639, rightmost screen pixel
- SPRITE_W, 16, sprite width; rightmost legal X = X_MAX-SPRITE_W+1
- STEP, 2, horizontal pixels per frame
- JUMP_V, 12, initial upward velocity (pixels/frame); also the terminal falling speed
- KEY_LEFT, 8'h04, HID code 'A'
- KEY_RIGHT, 8'h07, HID code 'D'
- KEY_JUMP, 8'h1A, HID code 'W'

Ports:
- clk_clk  in  1  system clock (50 MHz)
- reset_reset  in  1  asynchronous, active-high reset
- keycode  in  32  four HID usage bytes [7:0],[15:8],[23:16],[31:24]; 8'h00 = empty slot
- frame_vs  in  1  VGA vsync, synchronous to clk_clk
- pos_x  out  10  player X
- pos_y  out  10  player Y
- in_air  out  1  1 while the jump FSM is in AIR
- facing_left  out  1  last horizontal direction moved
- frame_tick  out  1  one-cycle pulse on each detected frame edge

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: pos_x=X_INIT, pos_y=Y_GROUND, in_air=0, facing_left=0, frame_tick=0, FSM=GROUND, vy=0, vs_d=0.
- Frame tick: vs_d registers frame_vs. tick = frame_vs & ~vs_d (rising edge).
  - frame_tick is registered, so it is high the cycle after the edge is sampled.
  - All position/FSM updates occur on the same clock edge that sets frame_tick. Latency is 1 cycle from the sampled vsync edge.
- Key decode (combinational):
  - L/R/J = any of the four bytes equals KEY_LEFT/KEY_RIGHT/KEY_JUMP.
  - Zero bytes never match.
  - Decode is sampled only on tick; key changes between ticks are ignored.
- Horizontal update (per tick):
  - L&~R: pos_x = max(pos_x-STEP, X_MIN), facing_left=1.
  - R&~L: pos_x = min(pos_x+STEP, X_MAX-SPRITE_W+1), facing_left=0.
  - Both pressed or neither: no change.
  - Use 11-bit signed intermediates so the result never wraps.
- Vertical: vy is signed 6-bit, positive = up.
- FSM states and transitions:
  - GROUND: on tick with J, vy=JUMP_V and go to AIR; pos_y is unchanged this tick.
  - AIR, each tick:
    - y_n = pos_y - vy; vy_n = max(vy-1, -JUMP_V).
    - If y_n < 0: pos_y=0, vy=0 (ceiling clamp).
    - Else if y_n >= Y_GROUND: pos_y=Y_GROUND, vy=0, go to LAND.
    - Else: pos_y=y_n, vy=vy_n.
  - LAND: on tick, go to GROUND only if ~J. Holding W never auto-repeats the jump.
- in_air = (state==AIR).
- Horizontal motion is permitted in all states.
- Reset asserted mid-jump: immediate return to the reset values, without waiting for the clock or a tick.
- A vsync edge that arrives during reset is ignored; the first tick needs a fresh rising edge after reset deasserts with vs_d=0. Consequently, if frame_vs is already 1 at deassert, it counts as an edge.

Optional Feature:
- Macro: PLAYER_DOUBLE_JUMP_EN
- Defined:
  - A 1-bit jump-latch register stores J at each tick.
  - In AIR, a tick with J & ~j_prev & ~dj_used sets vy=JUMP_V and dj_used=1; pos_y still updates using the old vy that tick.
  - dj_used clears on entering GROUND and on reset.
  - Only one extra jump per airtime.
- Undefined: no latch or dj_used logic; a new J press in AIR is ignored.

Test Plan:
- Reset → pos_x=320, pos_y=400, in_air=0, facing_left=0, frame_tick=0. Release reset with frame_vs=0; vsync idle → no change.
- keycode=32'h0000_0007, 200 frames → pos_x climbs 322, 324, … and saturates at 624; facing_left=0. Then keycode=32'h0004_0000 → pos_x=622, facing_left=1.
- keycode=32'h0704_0000 (A and D) for 10 frames → pos_x unchanged, facing_left unchanged.
- keycode=32'h0000_001A for 1 frame, then 0:
  - tick1 in_air=1, pos_y=400.
  - Following ticks: 388, 377, …; peak 322 after 12 AIR ticks, then 322 again.
  - Falls back and reaches pos_y=400 with in_air=0 after 25 AIR ticks.
- Hold W continuously through landing → FSM stays in LAND, no second jump. Release W one frame, then press W → new jump starts.
- Reset asserted mid-flight (pos_y=350) between ticks → pos_y=400 and in_air=0 immediately without a clock edge. With PLAYER_DOUBLE_JUMP_EN: press/release/press W in air → vy reloads to 12 once; a third press has no effect.

Source files
------------

// File: rtl/player_motion_ctrl.sv
// Per-frame player 1 motion: walk left/right and a gravity jump FSM stepped on each vsync rising edge.
// Optional build macro PLAYER_DOUBLE_JUMP_EN enables a single mid-air re-jump per airtime.
module player_motion_ctrl #(
  parameter logic [9:0] X_INIT    = 10'd320,
  parameter logic [9:0] Y_GROUND  = 10'd400,
  parameter logic [9:0] X_MIN     = 10'd0,
  parameter logic [9:0] X_MAX     = 10'd639,
  parameter logic [9:0] SPRITE_W  = 10'd16,
  parameter logic [9:0] STEP      = 10'd2,
  parameter logic [5:0] JUMP_V    = 6'd12,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07,
  parameter logic [7:0] KEY_JUMP  = 8'h1A
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] keycode,
  input  logic        frame_vs,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        in_air,
  output logic        facing_left,
  output logic        frame_tick
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_LAND   = 2'd2
  } state_t;

  localparam logic signed [10:0] X_LO    = $signed({1'b0, X_MIN});
  localparam logic signed [10:0] X_HI    = $signed({1'b0, X_MAX - SPRITE_W + 10'd1});
  localparam logic signed [10:0] Y_GND   = $signed({1'b0, Y_GROUND});
  localparam logic signed [10:0] X_STEP  = $signed({1'b0, STEP});
  localparam logic signed [5:0]  VY_JUMP = $signed(JUMP_V);
  localparam logic signed [5:0]  VY_TERM = -$signed(JUMP_V);

  // An empty slot (8'h00) must never match, even if a key code parameter were zero.
  function automatic logic key_hit(input logic [31:0] kc, input logic [7:0] code);
    key_hit = (code != 8'h00) &&
              ((kc[7:0] == code) || (kc[15:8] == code) ||
               (kc[23:16] == code) || (kc[31:24] == code));
  endfunction

  state_t             state_r, state_n;
  logic               vs_d_r;
  logic               tick_s;
  logic [9:0]         pos_x_r, pos_x_n;
  logic [9:0]         pos_y_r, pos_y_n;
  logic signed [5:0]  vy_r, vy_n;
  logic               face_r, face_n;
  logic               in_air_r;
  logic               frame_tick_r;
  logic               key_l_s, key_r_s, key_j_s;
  logic signed [10:0] x_dec_s, x_inc_s, y_next_s;
  logic signed [5:0]  vy_dec_s, vy_fall_s;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic               j_prev_r, j_prev_n;
  logic               dj_used_r, dj_used_n;
`endif

  assign tick_s    = frame_vs & ~vs_d_r;
  assign key_l_s   = key_hit(keycode, KEY_LEFT);
  assign key_r_s   = key_hit(keycode, KEY_RIGHT);
  assign key_j_s   = key_hit(keycode, KEY_JUMP);
  assign x_dec_s   = $signed({1'b0, pos_x_r}) - X_STEP;
  assign x_inc_s   = $signed({1'b0, pos_x_r}) + X_STEP;
  assign y_next_s  = $signed({1'b0, pos_y_r}) - $signed({{5{vy_r[5]}}, vy_r});
  assign vy_dec_s  = vy_r - 6'sd1;
  assign vy_fall_s = (vy_dec_s < VY_TERM) ? VY_TERM : vy_dec_s;

  // Next-state, position and velocity; everything holds between ticks.
  always_comb begin
    state_n = state_r;
    pos_x_n = pos_x_r;
    pos_y_n = pos_y_r;
    vy_n    = vy_r;
    face_n  = face_r;
`ifdef PLAYER_DOUBLE_JUMP_EN
    j_prev_n  = j_prev_r;
    dj_used_n = dj_used_r;
`endif
    if (tick_s) begin
      if (key_l_s && !key_r_s) begin
        pos_x_n = (x_dec_s < X_LO) ? X_LO[9:0] : x_dec_s[9:0];
        face_n  = 1'b1;
      end else if (key_r_s && !key_l_s) begin
        pos_x_n = (x_inc_s > X_HI) ? X_HI[9:0] : x_inc_s[9:0];
        face_n  = 1'b0;
      end else begin
        pos_x_n = pos_x_r;
        face_n  = face_r;
      end

      case (state_r)
        ST_GROUND: begin
          if (key_j_s) begin
            vy_n    = VY_JUMP;
            state_n = ST_AIR;
          end else begin
            state_n = ST_GROUND;
          end
        end
        ST_AIR: begin
          if (y_next_s < 11'sd0) begin
            pos_y_n = 10'd0;
            vy_n    = 6'sd0;
          end else if (y_next_s >= Y_GND) begin
            pos_y_n = Y_GROUND;
            vy_n    = 6'sd0;
            state_n = ST_LAND;
          end else begin
            pos_y_n = y_next_s[9:0];
            vy_n    = vy_fall_s;
          end
        end
        ST_LAND: begin
          if (!key_j_s) begin
            state_n = ST_GROUND;
          end else begin
            state_n = ST_LAND;
          end
        end
        default: begin
          state_n = ST_GROUND;
          vy_n    = 6'sd0;
        end
      endcase

`ifdef PLAYER_DOUBLE_JUMP_EN
      // Re-jump needs a fresh press; position already moved with the old velocity.
      j_prev_n = key_j_s;
      if ((state_r == ST_AIR) && (state_n == ST_AIR) && key_j_s && !j_prev_r && !dj_used_r) begin
        vy_n      = VY_JUMP;
        dj_used_n = 1'b1;
      end else if (state_n == ST_GROUND) begin
        dj_used_n = 1'b0;
      end else begin
        dj_used_n = dj_used_r;
      end
`endif
    end else begin
      state_n = state_r;
    end
  end

  // State, position and output registers with asynchronous reset.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_r      <= ST_GROUND;
      vs_d_r       <= 1'b0;
      pos_x_r      <= X_INIT;
      pos_y_r      <= Y_GROUND;
      vy_r         <= 6'sd0;
      face_r       <= 1'b0;
      in_air_r     <= 1'b0;
      frame_tick_r <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
      j_prev_r     <= 1'b0;
      dj_used_r    <= 1'b0;
`endif
    end else begin
      state_r      <= state_n;
      vs_d_r       <= frame_vs;
      pos_x_r      <= pos_x_n;
      pos_y_r      <= pos_y_n;
      vy_r         <= vy_n;
      face_r       <= face_n;
      in_air_r     <= (state_n == ST_AIR);
      frame_tick_r <= tick_s;
`ifdef PLAYER_DOUBLE_JUMP_EN
      j_prev_r     <= j_prev_n;
      dj_used_r    <= dj_used_n;
`endif
    end
  end

  assign pos_x       = pos_x_r;
  assign pos_y       = pos_y_r;
  assign in_air      = in_air_r;
  assign facing_left = face_r;
  assign frame_tick  = frame_tick_r;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: a behavioural model queues expected state per frame,
// compared when frame_tick is seen; fixed trajectory tables cross-check the model.
module tb_player_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] keycode;
  logic        frame_vs;
  logic [9:0]  pos_x, pos_y;
  logic        in_air, facing_left, frame_tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    int air;
    int face;
  } exp_t;
  exp_t sb_q[$];

  int mx, my, mvy, mst, mface, mjprev, mdj;
  int traj[25] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322, 322,
                   323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400};

  player_motion_ctrl dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .keycode     (keycode),
    .frame_vs    (frame_vs),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .in_air      (in_air),
    .facing_left (facing_left),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic bit has_key(input logic [31:0] kc, input logic [7:0] code);
    logic [7:0] b;
    has_key = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = kc[i*8 +: 8];
      if (b != 8'h00 && b == code) has_key = 1'b1;
    end
  endfunction

  task automatic model_reset();
    mx = 320; my = 400; mvy = 0; mst = 0; mface = 0; mjprev = 0; mdj = 0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic [31:0] kc);
    bit l, r, j;
    int yn;
    l = has_key(kc, 8'h04);
    r = has_key(kc, 8'h07);
    j = has_key(kc, 8'h1A);
    if (l && !r) begin
      mx = (mx - 2 < 0) ? 0 : mx - 2;
      mface = 1;
    end else if (r && !l) begin
      mx = (mx + 2 > 624) ? 624 : mx + 2;
      mface = 0;
    end
    if (mst == 0) begin
      if (j) begin mvy = 12; mst = 1; end
    end else if (mst == 1) begin
      yn = my - mvy;
      if (yn < 0) begin
        my = 0; mvy = 0;
      end else if (yn >= 400) begin
        my = 400; mvy = 0; mst = 2;
      end else begin
        my = yn;
        mvy = (mvy - 1 < -12) ? -12 : mvy - 1;
      end
`ifdef PLAYER_DOUBLE_JUMP_EN
      if (mst == 1 && j && !mjprev && !mdj) begin
        mvy = 12; mdj = 1;
      end
`endif
    end else begin
      if (!j) mst = 0;
    end
    if (mst == 0) mdj = 0;
    mjprev = j;
  endtask

  task automatic do_frame(input logic [31:0] kc);
    exp_t e;
    bit found;
    @(negedge clk);
    keycode  = kc;
    frame_vs = 1'b1;
    model_step(kc);
    e.x = mx; e.y = my; e.air = (mst == 1) ? 1 : 0; e.face = mface;
    sb_q.push_back(e);
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (frame_tick) begin
        found = 1'b1;
        break;
      end
    end
    frame_vs = 1'b0;
    if (!found) begin
      chk("tick_timeout", 0, 1);
      sb_q.delete();
    end else if (sb_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk("pos_x", pos_x, e.x);
      chk("pos_y", pos_y, e.y);
      chk("in_air", in_air, e.air);
      chk("facing", facing_left, e.face);
      @(negedge clk);
      chk("tick_pulse", frame_tick, 0);
    end
  endtask

  initial begin
    rst = 1'b1; keycode = 32'h0; frame_vs = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x", pos_x, 320);
    chk("rst_y", pos_y, 400);
    chk("rst_air", in_air, 0);
    chk("rst_face", facing_left, 0);
    chk("rst_tick", frame_tick, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_x", pos_x, 320);
    chk("idle_tick", frame_tick, 0);

    // walk right to the saturation point, then one step left
    do_frame(32'h0000_0007);
    chk("first_step", pos_x, 322);
    for (int i = 1; i < 200; i++) do_frame(32'h0000_0007);
    chk("x_sat", pos_x, 624);
    do_frame(32'h0004_0000);
    chk("left_x", pos_x, 622);
    chk("left_face", facing_left, 1);
    for (int i = 0; i < 10; i++) do_frame(32'h0704_0000);
    chk("both_x", pos_x, 622);
    chk("both_face", facing_left, 1);

    // single jump trajectory
    do_frame(32'h0000_001A);
    chk("jump_air", in_air, 1);
    chk("jump_y", pos_y, 400);
    for (int i = 0; i < 25; i++) begin
      do_frame(32'h0);
      chk("traj_y", pos_y, traj[i]);
      chk("traj_air", in_air, (i < 24) ? 1 : 0);
    end

    // held jump key must not re-trigger after landing
    for (int i = 0; i < 40; i++) do_frame(32'h0000_001A);
    chk("hold_air", in_air, 0);
    chk("hold_y", pos_y, 400);
    do_frame(32'h0);
    do_frame(32'h0000_001A);
    chk("rejump", in_air, 1);

    // asynchronous reset mid-flight
    for (int i = 0; i < 5; i++) do_frame(32'h0);
    chk("mid_y", pos_y, 350);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_y", pos_y, 400);
    chk("async_air", in_air, 0);
    chk("async_x", pos_x, 320);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // press/release/press in air: one reload at most
    do_frame(32'h0000_001A);
    do_frame(32'h0);
    do_frame(32'h0000_001A);
    do_frame(32'h0);
`ifdef PLAYER_DOUBLE_JUMP_EN
    chk("dj_y4", pos_y, 365);
`else
    chk("dj_y4", pos_y, 367);
`endif
    do_frame(32'h0000_001A);
    do_frame(32'h0);
`ifdef PLAYER_DOUBLE_JUMP_EN
    chk("dj_y6", pos_y, 344);
`else
    chk("dj_y6", pos_y, 350);
`endif
    for (int i = 0; i < 45; i++) do_frame(32'h0);
    chk("dj_land_y", pos_y, 400);
    chk("dj_land_air", in_air, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
